// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared operation codes and default width for the shifter datapath
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ROR = 2'b10,
    SH_ROL = 2'b11
  } shift_type_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational logical/rotate shifter, result width equals operand width
module barrel_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] res
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] tmp;

  // Rotates shift a doubled copy of the operand and pick the wrapped half.
  always_comb begin
    dbl = {data, data};
    tmp = '0;
    res = '0;
    case (shift_type_e'(op))
      SH_LSL: res = data << amt;
      SH_LSR: res = data >> amt;
      SH_ROR: begin
        tmp = dbl >> amt;
        res = tmp[WIDTH-1:0];
      end
      SH_ROL: begin
        tmp = dbl << amt;
        res = tmp[2*WIDTH-1:WIDTH];
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one barrel_shifter among NUM_REQ requesters
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_REQ = 4,
  localparam int AMT_W  = $clog2(WIDTH),
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0] req_amt,
  input  logic [NUM_REQ*2-1:0]     req_type,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            can_accept;
  logic            grant;

  logic [WIDTH-1:0] data_arr [NUM_REQ];
  logic [AMT_W-1:0] amt_arr  [NUM_REQ];
  logic [1:0]       type_arr [NUM_REQ];
  logic [WIDTH-1:0] shift_res;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
      amt_arr[i]  = req_amt[i*AMT_W +: AMT_W];
      type_arr[i] = req_type[i*2 +: 2];
    end
  end

  // First valid requester found walking upward from rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign rsp_valid  = (state == FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  assign grant      = !rst && can_accept && found;
  assign req_ready  = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

  barrel_shifter #(.WIDTH(WIDTH)) u_shifter (
    .data (data_arr[gnt_idx]),
    .amt  (amt_arr[gnt_idx]),
    .op   (type_arr[gnt_idx]),
    .res  (shift_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (grant) begin
      state    <= FULL;
      rsp_data <= shift_res;
      rsp_id   <= gnt_idx;
      rr_ptr   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter with directed vectors
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [11:0] req_amt;
  logic [7:0]  req_type;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  shift_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_type  (req_type),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a, input logic [1:0] t);
    req_data[i*8 +: 8] = d;
    req_amt[i*3 +: 3]  = a;
    req_type[i*2 +: 2] = t;
    req_valid[i]       = 1'b1;
  endtask

  // Checks grant and response-valid for the current cycle, queues the expected result on a grant.
  task automatic step(input logic [3:0] exp_ready, input logic exp_valid,
                      input logic push, input logic [7:0] d, input logic [1:0] id);
    exp_t e;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (push) begin
      e.data = d;
      e.id   = id;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_rsp: got data %0h id %0d expected none", rsp_data, rsp_id);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'h0;
    req_data  = '0;
    req_amt   = '0;
    req_type  = '0;
    @(posedge clk);
    #1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 4'h0;
    rst       = 1'b0;

    // single request
    rsp_ready = 1'b1;
    set_req(0, 8'h81, 3'd1, 2'b10);
    step(4'b0001, 1'b0, 1'b1, 8'hC0, 2'd0);
    req_valid = 4'h0;
    step(4'b0000, 1'b1, 1'b0, 8'h00, 2'd0);

    // full contention, also covers the arithmetic corners
    do_reset();
    set_req(0, 8'h0F, 3'd7, 2'b00);
    set_req(1, 8'hF0, 3'd4, 2'b01);
    set_req(2, 8'h01, 3'd7, 2'b10);
    set_req(3, 8'hA5, 3'd0, 2'b11);
    step(4'b0001, 1'b0, 1'b1, 8'h80, 2'd0);
    step(4'b0010, 1'b1, 1'b1, 8'h0F, 2'd1);
    step(4'b0100, 1'b1, 1'b1, 8'h02, 2'd2);
    step(4'b1000, 1'b1, 1'b1, 8'hA5, 2'd3);
    step(4'b0001, 1'b1, 1'b1, 8'h80, 2'd0);
    req_valid = 4'h0;
    step(4'b0000, 1'b1, 1'b0, 8'h00, 2'd0);
    step(4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);

    // backpressure: rr_ptr is 1 here
    rsp_ready = 1'b0;
    set_req(1, 8'h0F, 3'd2, 2'b00);
    step(4'b0010, 1'b0, 1'b1, 8'h3C, 2'd1);
    req_valid = 4'h0;
    set_req(2, 8'h55, 3'd1, 2'b01);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_data", 32'(rsp_data), 32'h3C);
      chk("bp_rsp_id", 32'(rsp_id), 32'd1);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    step(4'b0100, 1'b1, 1'b1, 8'h2A, 2'd2);
    req_valid = 4'h0;
    step(4'b0000, 1'b1, 1'b0, 8'h00, 2'd0);

    // pointer advance
    set_req(2, 8'h81, 3'd1, 2'b11);
    step(4'b0100, 1'b0, 1'b1, 8'h03, 2'd2);
    req_valid = 4'h0;
    set_req(1, 8'h80, 3'd7, 2'b01);
    set_req(3, 8'h02, 3'd1, 2'b00);
    step(4'b1000, 1'b1, 1'b1, 8'h04, 2'd3);
    req_valid[3] = 1'b0;
    step(4'b0010, 1'b1, 1'b1, 8'h01, 2'd1);
    req_valid = 4'h0;
    step(4'b0000, 1'b1, 1'b0, 8'h00, 2'd0);

    // reset mid-operation: the held result is discarded; rr_ptr is 2 here
    rsp_ready = 1'b0;
    set_req(0, 8'h11, 3'd0, 2'b00);
    step(4'b0001, 1'b0, 1'b1, 8'h11, 2'd0);
    req_valid = 4'h0;
    set_req(3, 8'h10, 3'd4, 2'b01);
    set_req(0, 8'h3C, 3'd1, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_held_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    rsp_ready = 1'b1;
    step(4'b0001, 1'b0, 1'b1, 8'h78, 2'd0);
    req_valid[0] = 1'b0;
    step(4'b1000, 1'b1, 1'b1, 8'h01, 2'd3);
    req_valid = 4'h0;
    step(4'b0000, 1'b1, 1'b0, 8'h00, 2'd0);
    step(4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
